slow_tick_hex_display: RTL and testbench

- Timing-and-display front end for the board-level counters.
- Divides CLOCK_50 down to a one-cycle slow tick, currently 1 Hz, gated by an enable switch.
- Decodes a 16-bit value into four active-low seven-segment digit patterns, one nibble per HEX display.
- Consumers increment their digit registers on tick and feed the digits back through value for display.

---
 rtl/slow_tick_hex_display_pkg.sv | 60 ++++++
 rtl/slow_tick_hex_display_if.sv | 15 +
 rtl/slow_tick_hex_display_seven_seg_decoder.sv | 9 +
 rtl/slow_tick_hex_display.sv | 46 ++++
 tb/tb_slow_tick_hex_display.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/slow_tick_hex_display_pkg.sv
// Shared constants for the slow-tick / hex-display front end: segment patterns,
// segment bit positions and the board-default divisor.
package slow_tick_hex_display_pkg;

  localparam int unsigned DEFAULT_DIVISOR = 50_000_000;
  localparam int unsigned SEG_W           = 7;

  // Bit position of each segment inside a pattern; a segment lights when its bit is 0.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F_IDX = 5;
  localparam int unsigned SEG_G = 6;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A_GLYPH = 7'b0001000;
  localparam seg_t SEG_B_GLYPH = 7'b0000011;
  localparam seg_t SEG_C_GLYPH = 7'b1000110;
  localparam seg_t SEG_D_GLYPH = 7'b0100001;
  localparam seg_t SEG_E_GLYPH = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;

  // Total over all 16 nibbles, so no blank or X pattern can ever be produced.
  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A_GLYPH;
      4'hB: seg = SEG_B_GLYPH;
      4'hC: seg = SEG_C_GLYPH;
      4'hD: seg = SEG_D_GLYPH;
      4'hE: seg = SEG_E_GLYPH;
      4'hF: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/slow_tick_hex_display_if.sv
// Board-side bundle: enable/value towards the display block, tick and digit patterns back.
interface slow_tick_hex_display_if;
  import slow_tick_hex_display_pkg::*;

  logic        enable;
  logic [15:0] value;
  logic        tick;
  seg_t        hex0;
  seg_t        hex1;
  seg_t        hex2;
  seg_t        hex3;

  modport master (output enable, value, input tick, hex0, hex1, hex2, hex3);
  modport slave  (input enable, value, output tick, hex0, hex1, hex2, hex3);
endinterface

// File: rtl/slow_tick_hex_display_seven_seg_decoder.sv
// One hex digit: 4-bit nibble to active-low seven-segment pattern, purely combinational.
module seven_seg_decoder
  import slow_tick_hex_display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);
  assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/slow_tick_hex_display.sv
// Clock divider producing a one-cycle enable-gated tick, plus four hex digit decoders.
module slow_tick_hex_display
  import slow_tick_hex_display_pkg::*;
#(
  parameter int unsigned DIVISOR = DEFAULT_DIVISOR,
  parameter int unsigned CNT_W   = 26
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        enable,
  input  logic [15:0] value,
  output logic        tick,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CNT_W'(1);
    end
  end

  // NOTE: non-blocking so every flop samples pre-edge values; reset is synchronous here.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) cnt_q <= RELOAD;
    else         cnt_q <= cnt_d;
  end

  // Gated by enable so a tick pending at zero waits for enable to return.
  assign tick = enable & (cnt_q == '0);

  seven_seg_decoder u_dec0 (.nibble(value[3:0]),   .seg(HEX0));
  seven_seg_decoder u_dec1 (.nibble(value[7:4]),   .seg(HEX1));
  seven_seg_decoder u_dec2 (.nibble(value[11:8]),  .seg(HEX2));
  seven_seg_decoder u_dec3 (.nibble(value[15:12]), .seg(HEX3));

endmodule

// File: tb/tb_slow_tick_hex_display.sv
// Self-checking bench: a DIVISOR=4 and a DIVISOR=1 instance share stimulus; a cycle-count
// model predicts tick, a literal glyph table predicts the digit patterns.
module tb_slow_tick_hex_display;

  localparam logic [6:0] SEG_REF [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam int unsigned DIV_A = 4;

  typedef struct {
    logic [15:0] value;
    logic        resetn;
    logic [6:0]  h0, h1, h2, h3;
  } hex_vec_t;

  logic clk = 1'b0;
  logic resetn;
  logic tick1;
  logic [6:0] b_hex0, b_hex1, b_hex2, b_hex3;

  int errors = 0;
  int checks = 0;
  int unsigned n_en = 0;   // enabled edges since last reset edge

  slow_tick_hex_display_if bus ();

  always #5 clk = ~clk;

  slow_tick_hex_display #(.DIVISOR(DIV_A), .CNT_W(3)) dut_a (
    .CLOCK_50(clk), .resetn(resetn), .enable(bus.enable), .value(bus.value),
    .tick(bus.tick), .HEX0(bus.hex0), .HEX1(bus.hex1), .HEX2(bus.hex2), .HEX3(bus.hex3)
  );

  slow_tick_hex_display #(.DIVISOR(1), .CNT_W(1)) dut_b (
    .CLOCK_50(clk), .resetn(resetn), .enable(bus.enable), .value(bus.value),
    .tick(tick1), .HEX0(b_hex0), .HEX1(b_hex1), .HEX2(b_hex2), .HEX3(b_hex3)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic rst, input logic en);
    @(posedge clk);
    if (!rst)    n_en = 0;
    else if (en) n_en++;
  endtask

  task automatic check_hex(input logic [15:0] val);
    check("hex0", {9'd0, bus.hex0}, {9'd0, SEG_REF[val[3:0]]});
    check("hex1", {9'd0, bus.hex1}, {9'd0, SEG_REF[val[7:4]]});
    check("hex2", {9'd0, bus.hex2}, {9'd0, SEG_REF[val[11:8]]});
    check("hex3", {9'd0, bus.hex3}, {9'd0, SEG_REF[val[15:12]]});
  endtask

  // One cycle: drive after the falling edge, check combinational outputs, then clock.
  // hand >= 0 adds an explicitly written expectation for the DIVISOR=4 tick.
  task automatic step(input logic rst, input logic en, input logic [15:0] val, input int hand);
    logic exp_tick;
    @(negedge clk);
    resetn     = rst;
    bus.enable = en;
    bus.value  = val;
    #1;
    exp_tick = en && ((n_en % DIV_A) == DIV_A - 1);
    check("tick_div4_model", {15'd0, bus.tick}, {15'd0, exp_tick});
    check("tick_div1", {15'd0, tick1}, {15'd0, en});
    check_hex(val);
    if (hand >= 0) check("tick_div4_seq", {15'd0, bus.tick}, 16'(hand));
    model_update(rst, en);
  endtask

  initial begin
    hex_vec_t vecs [18];

    for (int i = 0; i < 16; i++)
      vecs[i] = '{16'(i), 1'b1, SEG_REF[i], 7'b1000000, 7'b1000000, 7'b1000000};
    vecs[16] = '{16'h9A5C, 1'b0, 7'b1000110, 7'b0010010, 7'b0001000, 7'b0010000};
    vecs[17] = '{16'h9A5C, 1'b1, 7'b1000110, 7'b0010010, 7'b0001000, 7'b0010000};

    resetn     = 1'b0;
    bus.enable = 1'b1;
    bus.value  = 16'h0000;
    model_update(1'b0, 1'b1);

    // Reset held 3 cycles, then ticks on the 4th, 8th and 12th enabled cycles.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1234, 0);
    for (int i = 1; i <= 12; i++) step(1'b1, 1'b1, 16'h1234, (i % 4 == 0) ? 1 : 0);

    // Enable dropped for 5 cycles after 2 enabled cycles: the counter holds.
    step(1'b0, 1'b1, 16'h0000, 0);
    step(1'b1, 1'b1, 16'h0000, 0);
    step(1'b1, 1'b1, 16'h0000, 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0000, 0);
    step(1'b1, 1'b1, 16'h0000, 0);
    step(1'b1, 1'b1, 16'h0000, 1);

    // Reset while the counter sits at 1 restarts the whole period.
    step(1'b0, 1'b1, 16'hFFFF, 0);
    step(1'b1, 1'b1, 16'hFFFF, 0);
    step(1'b1, 1'b1, 16'hFFFF, 0);
    step(1'b0, 1'b1, 16'hFFFF, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'hFFFF, 0);
    step(1'b1, 1'b1, 16'hFFFF, 1);

    // Enable dropped exactly when the tick is due: suppressed, then fires on return.
    step(1'b0, 1'b1, 16'h8421, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h8421, 0);
    step(1'b1, 1'b0, 16'h8421, 0);
    step(1'b1, 1'b0, 16'h8421, 0);
    step(1'b1, 1'b1, 16'h8421, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h8421, 0);
    step(1'b1, 1'b1, 16'h8421, 1);

    // DIVISOR=1 instance must mirror enable as it toggles.
    for (int i = 0; i < 8; i++) step(1'b1, logic'(i % 2), 16'h0F0F, -1);

    // Decoder table, including a value applied while reset is asserted.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      resetn     = vecs[i].resetn;
      bus.enable = 1'b0;
      bus.value  = vecs[i].value;
      #1;
      check("tbl_hex0", {9'd0, bus.hex0}, {9'd0, vecs[i].h0});
      check("tbl_hex1", {9'd0, bus.hex1}, {9'd0, vecs[i].h1});
      check("tbl_hex2", {9'd0, bus.hex2}, {9'd0, vecs[i].h2});
      check("tbl_hex3", {9'd0, bus.hex3}, {9'd0, vecs[i].h3});
      check("tbl_b_hex0", {9'd0, b_hex0}, {9'd0, vecs[i].h0});
      check("tbl_b_hex3", {9'd0, b_hex3}, {9'd0, vecs[i].h3});
      model_update(vecs[i].resetn, 1'b0);
    end

    // Randomised traffic against the cycle-count model.
    for (int i = 0; i < 400; i++) begin
      logic r, e;
      r = ($urandom_range(0, 19) != 0);
      e = ($urandom_range(0, 3) != 0);
      step(r, e, 16'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
